// File: rtl/axis_video_mon.sv
// -----------------------------------------------------------------------------
// axis_video_mon
//
// Inline AXI4-Stream video monitor. The stream path is a pure wire-through
// (zero latency, never stalls, alters or drops a beat). Alongside it, a
// registered side channel measures the video geometry and rates, and flags
// malformed line/frame structure with sticky error bits.
//
// Ports
//   aclk, aresetn         clock; synchronous active-low reset
//   s_axis_*              upstream stream (tvalid/tready/tdata/tlast/tuser)
//   m_axis_*              downstream stream, mirrors s_axis_*
//   clr_sticky            one-cycle clear of the err_* bits
//   width_o               beats per line of the last complete frame
//   height_o              lines in the last complete frame
//   fps_o                 frames started in the last completed window
//   stall_o               tvalid & !tready cycles in the last completed window
//   frame_cnt_o           frames completed since reset (wraps)
//   meas_valid_o          pulse when width_o/height_o/frame_cnt_o update
//   err_eol_early_o       a line shorter than the frame's first line
//   err_eol_late_o        a line longer than the frame's first line
//   err_sof_early_o       SOF arrived in the middle of a line
// -----------------------------------------------------------------------------
module axis_video_mon #(
    parameter int TDATA_WIDTH = 48,
    parameter int TUSER_WIDTH = 1,
    parameter int FREQ_HZ     = 100000000,
    parameter int DIM_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,

    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,

    input  logic                   clr_sticky,
    output logic [DIM_WIDTH-1:0]   width_o,
    output logic [DIM_WIDTH-1:0]   height_o,
    output logic [15:0]            fps_o,
    output logic [31:0]            stall_o,
    output logic [31:0]            frame_cnt_o,
    output logic                   meas_valid_o,
    output logic                   err_eol_early_o,
    output logic                   err_eol_late_o,
    output logic                   err_sof_early_o
);

    localparam int WIN_W = (FREQ_HZ > 1) ? $clog2(FREQ_HZ) : 1;
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(FREQ_HZ - 1);
    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] DIM_MAX  = '1;

    // Sticky error bit positions
    localparam int E_EARLY = 0;
    localparam int E_LATE  = 1;
    localparam int E_SOF   = 2;

    // ---------------------------------------------------------------- passthrough
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign s_axis_tready = m_axis_tready;

    // ---------------------------------------------------------------- events
    logic beat, sof, eol, stall;
    assign beat  = s_axis_tvalid & m_axis_tready;
    assign sof   = beat & s_axis_tuser[0];
    assign eol   = beat & s_axis_tlast;
    assign stall = s_axis_tvalid & ~m_axis_tready;

    // ---------------------------------------------------------------- state
    logic [DIM_WIDTH-1:0] pix_cnt_q,   pix_cnt_d;
    logic [DIM_WIDTH-1:0] line_cnt_q,  line_cnt_d;
    logic [DIM_WIDTH-1:0] ref_w_q,     ref_w_d;
    logic                 ref_valid_q, ref_valid_d;
    logic                 seen_sof_q,  seen_sof_d;
    logic [DIM_WIDTH-1:0] width_q,     width_d;
    logic [DIM_WIDTH-1:0] height_q,    height_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic                 meas_q,      meas_d;
    logic [WIN_W-1:0]     win_cnt_q,   win_cnt_d;
    logic [15:0]          win_frames_q, win_frames_d;
    logic [31:0]          win_stall_q, win_stall_d;
    logic [15:0]          fps_q,       fps_d;
    logic [31:0]          stall_q,     stall_d;
    logic [2:0]           err_q,       err_d;
    logic [2:0]           err_set;

    logic [DIM_WIDTH-1:0] line_len;
    logic [15:0]          frames_inc;
    logic [31:0]          stall_inc;
    logic                 win_end;

    // Length of the line closed by this beat, saturating like pix_cnt.
    assign line_len = (pix_cnt_q == DIM_MAX) ? DIM_MAX : pix_cnt_q + DIM_ONE;

    // Window accumulators including the current cycle, so that an event on the
    // terminal cycle still lands in the window it belongs to.
    assign frames_inc = (sof && win_frames_q != 16'hFFFF) ? win_frames_q + 16'd1 : win_frames_q;
    assign stall_inc  = (stall && win_stall_q != 32'hFFFF_FFFF) ? win_stall_q + 32'd1 : win_stall_q;
    assign win_end    = (win_cnt_q == WIN_LAST);

    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        ref_w_d     = ref_w_q;
        ref_valid_d = ref_valid_q;
        seen_sof_d  = seen_sof_q;
        width_d     = width_q;
        height_d    = height_q;
        frame_cnt_d = frame_cnt_q;
        meas_d      = 1'b0;
        err_set     = 3'b000;

        // Pixel counter: the SOF beat is pixel 1 of the new line.
        if (beat) begin
            if (sof) begin
                pix_cnt_d = eol ? '0 : DIM_ONE;
            end else if (eol) begin
                pix_cnt_d = '0;
            end else if (pix_cnt_q != DIM_MAX) begin
                pix_cnt_d = pix_cnt_q + DIM_ONE;
            end
        end

        if (sof) begin
            // A mid-line SOF discards the partial line: it is simply never
            // counted because line_cnt only advances on eol.
            err_set[E_SOF] = (pix_cnt_q != '0);
            seen_sof_d     = 1'b1;
            if (seen_sof_q) begin
                width_d     = ref_w_q;
                height_d    = line_cnt_q + {{(DIM_WIDTH-1){1'b0}}, eol};
                frame_cnt_d = frame_cnt_q + 32'd1;
                meas_d      = 1'b1;
            end
            // A SOF+tlast beat is a complete one-beat first line.
            ref_valid_d = eol;
            line_cnt_d  = eol ? DIM_ONE : '0;
            if (eol) begin
                ref_w_d = DIM_ONE;
            end
        end else if (eol) begin
            if (!ref_valid_q) begin
                ref_w_d     = line_len;
                ref_valid_d = 1'b1;
            end else begin
                err_set[E_EARLY] = (line_len < ref_w_q);
                err_set[E_LATE]  = (line_len > ref_w_q);
            end
            if (line_cnt_q != DIM_MAX) begin
                line_cnt_d = line_cnt_q + DIM_ONE;
            end
        end
    end

    // Measurement window
    always_comb begin
        win_cnt_d    = win_end ? '0 : win_cnt_q + WIN_W'(1);
        win_frames_d = win_end ? 16'd0 : frames_inc;
        win_stall_d  = win_end ? 32'd0 : stall_inc;
        fps_d        = win_end ? frames_inc : fps_q;
        stall_d      = win_end ? stall_inc : stall_q;
    end

    // Sticky errors: a set event beats a simultaneous clear.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_err
            assign err_d[gi] = (err_q[gi] & ~clr_sticky) | err_set[gi];
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            ref_w_q      <= '0;
            ref_valid_q  <= 1'b0;
            seen_sof_q   <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            frame_cnt_q  <= '0;
            meas_q       <= 1'b0;
            win_cnt_q    <= '0;
            win_frames_q <= '0;
            win_stall_q  <= '0;
            fps_q        <= '0;
            stall_q      <= '0;
            err_q        <= '0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            ref_w_q      <= ref_w_d;
            ref_valid_q  <= ref_valid_d;
            seen_sof_q   <= seen_sof_d;
            width_q      <= width_d;
            height_q     <= height_d;
            frame_cnt_q  <= frame_cnt_d;
            meas_q       <= meas_d;
            win_cnt_q    <= win_cnt_d;
            win_frames_q <= win_frames_d;
            win_stall_q  <= win_stall_d;
            fps_q        <= fps_d;
            stall_q      <= stall_d;
            err_q        <= err_d;
        end
    end

    assign width_o         = width_q;
    assign height_o        = height_q;
    assign fps_o           = fps_q;
    assign stall_o         = stall_q;
    assign frame_cnt_o     = frame_cnt_q;
    assign meas_valid_o    = meas_q;
    assign err_eol_early_o = err_q[E_EARLY];
    assign err_eol_late_o  = err_q[E_LATE];
    assign err_sof_early_o = err_q[E_SOF];

endmodule

// File: tb/tb_axis_video_mon.sv
// -----------------------------------------------------------------------------
// tb_axis_video_mon
//
// Directed, table-driven bench for axis_video_mon with a 1000-cycle window.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_axis_video_mon;

    localparam int FREQ = 1000;
    localparam int DW   = 48;

    logic          aclk;
    logic          aresetn;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] s_tdata;
    logic [0:0]    s_tuser;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [0:0]    m_tuser;
    logic          clr;
    logic [15:0]   width_o, height_o, fps_o;
    logic [31:0]   stall_o, frame_cnt_o;
    logic          meas_o, e_early, e_late, e_sof;

    axis_video_mon #(
        .TDATA_WIDTH(DW),
        .TUSER_WIDTH(1),
        .FREQ_HZ    (FREQ),
        .DIM_WIDTH  (16)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tdata   (s_tdata),
        .s_axis_tlast   (s_tlast),
        .s_axis_tuser   (s_tuser),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tlast   (m_tlast),
        .m_axis_tuser   (m_tuser),
        .clr_sticky     (clr),
        .width_o        (width_o),
        .height_o       (height_o),
        .fps_o          (fps_o),
        .stall_o        (stall_o),
        .frame_cnt_o    (frame_cnt_o),
        .meas_valid_o   (meas_o),
        .err_eol_early_o(e_early),
        .err_eol_late_o (e_late),
        .err_sof_early_o(e_sof)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int kk    = 0;   // cycles since reset release
    int stalls = 0;  // tvalid & !tready cycles inside the first window
    int meas_seen = 0;

    typedef struct {
        logic        u;
        logic        l;
        logic        meas;
        logic [15:0] w;
        logic [15:0] h;
        logic [31:0] fc;
    } vec_t;

    vec_t tbl[36];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, check the wire-through, clock, settle.
    task automatic step(input logic v, input logic r, input logic u, input logic l, input logic c);
        logic [63:0] rnd;
        rnd      = {$urandom, $urandom};
        s_tvalid = v;
        m_tready = r;
        s_tuser  = u;
        s_tlast  = l;
        clr      = c;
        s_tdata  = rnd[DW-1:0];
        #1;
        chk("passthrough", {12'd0, m_tvalid, m_tdata, m_tlast, m_tuser, s_tready},
                           {12'd0, v, rnd[DW-1:0], l, u, r});
        if (aresetn && v && !r && kk < FREQ) stalls++;
        @(posedge aclk);
        #1;
        kk++;
        if (meas_o) meas_seen++;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        aresetn   = 1'b1;
        kk        = 0;
        stalls    = 0;
        meas_seen = 0;
    endtask

    task automatic send_line(input int n, input logic sof);
        for (int i = 0; i < n; i++) step(1, 1, sof && (i == 0), i == n - 1, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_width"},  width_o, 0);
        chk({tag, "_height"}, height_o, 0);
        chk({tag, "_fps"},    fps_o, 0);
        chk({tag, "_stall"},  stall_o, 0);
        chk({tag, "_fcnt"},   frame_cnt_o, 0);
        chk({tag, "_meas"},   meas_o, 0);
        chk({tag, "_errs"},   {e_early, e_late, e_sof}, 0);
    endtask

    initial begin
        s_tvalid = 0; m_tready = 1; s_tuser = 0; s_tlast = 0; s_tdata = '0; clr = 0;
        aresetn  = 0;

        // ---------------- reset state
        do_reset();
        chk_all_zero("reset");

        // ---------------- three 4x3 frames, tready high (table driven)
        begin
            int idx = 0;
            for (int f = 0; f < 3; f++)
                for (int l = 0; l < 3; l++)
                    for (int p = 0; p < 4; p++) begin
                        tbl[idx].u    = (l == 0 && p == 0);
                        tbl[idx].l    = (p == 3);
                        tbl[idx].meas = (l == 0 && p == 0 && f > 0);
                        tbl[idx].w    = (f > 0) ? 16'd4 : 16'd0;
                        tbl[idx].h    = (f > 0) ? 16'd3 : 16'd0;
                        tbl[idx].fc   = f;
                        idx++;
                    end
        end
        for (int i = 0; i < 36; i++) begin
            step(1, 1, tbl[i].u, tbl[i].l, 0);
            $display("vec %0d user=%0b last=%0b meas=%0b w=%0d h=%0d fc=%0d",
                     i, tbl[i].u, tbl[i].l, meas_o, width_o, height_o, frame_cnt_o);
            chk("t1_meas",  meas_o,      tbl[i].meas);
            chk("t1_width", width_o,     tbl[i].w);
            chk("t1_height", height_o,   tbl[i].h);
            chk("t1_fcnt",  frame_cnt_o, tbl[i].fc);
            chk("t1_errs",  {e_early, e_late, e_sof}, 0);
        end
        chk("t1_meas_count", meas_seen, 2);

        // ---------------- same stream, tready low every 3rd cycle
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < 3; l++)
                for (int p = 0; p < 4; p++) begin
                    logic r;
                    do begin
                        r = (kk % 3 != 2);
                        step(1, r, l == 0 && p == 0, p == 3, 0);
                    end while (!r);
                end
        while (kk < FREQ) step(0, 1, 0, 0, 0);
        $display("stall window: stall_o=%0d fps_o=%0d meas=%0d", stall_o, fps_o, meas_seen);
        chk("t2_width",  width_o, 4);
        chk("t2_height", height_o, 3);
        chk("t2_fcnt",   frame_cnt_o, 2);
        chk("t2_meas_count", meas_seen, 2);
        chk("t2_errs",   {e_early, e_late, e_sof}, 0);
        chk("t2_stall",  stall_o, stalls);
        chk("t2_fps",    fps_o, 3);

        // ---------------- line length errors and sticky clear
        do_reset();
        send_line(4, 1);
        chk("t3_no_err", {e_early, e_late}, 0);
        send_line(3, 0);
        chk("t3_early", e_early, 1);
        chk("t3_late0", e_late, 0);
        send_line(5, 0);
        chk("t3_late", e_late, 1);
        step(0, 1, 0, 0, 1);
        chk("t3_clr", {e_early, e_late}, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 1);
        chk("t3_set_wins", e_early, 1);
        chk("t3_late_clr", e_late, 0);
        $display("eol errors: early=%0b late=%0b", e_early, e_late);

        // ---------------- SOF on pixel 3 of a line
        do_reset();
        send_line(4, 1); send_line(4, 0); send_line(4, 0);
        send_line(4, 1); send_line(4, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("t4_sof_early", e_sof, 1);
        chk("t4_meas",      meas_o, 1);
        chk("t4_height",    height_o, 2);
        chk("t4_width",     width_o, 4);
        chk("t4_fcnt",      frame_cnt_o, 2);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        send_line(4, 0);
        send_line(4, 1);
        chk("t4_width2",  width_o, 4);
        chk("t4_height2", height_o, 2);
        chk("t4_eol_err", {e_early, e_late}, 0);
        $display("sof early: w=%0d h=%0d sof_err=%0b", width_o, height_o, e_sof);

        // ---------------- window rate: SOF every 100 cycles, one on terminal
        do_reset();
        while (kk < FREQ) begin
            logic v, u, r;
            u = (kk % 100 == 99);
            v = u || (kk == 50);
            r = (kk != 50);
            step(v, r, u, 0, 0);
            if (kk == FREQ - 1) chk("t5_fps_pre", fps_o, 0);
        end
        chk("t5_fps",   fps_o, 10);
        chk("t5_stall", stall_o, 1);
        chk("t5_fcnt",  frame_cnt_o, 9);
        chk("t5_sof",   e_sof, 1);
        $display("window: fps=%0d stall=%0d fc=%0d", fps_o, stall_o, frame_cnt_o);

        // ---------------- reset mid-frame
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        aresetn = 1'b0;
        step(0, 1, 0, 0, 0);
        aresetn = 1'b1;
        chk_all_zero("t6");
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        chk("t6_first_sof_meas", meas_o, 0);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 1, 0);
        send_line(4, 0); send_line(4, 0);
        step(1, 1, 1, 0, 0);
        chk("t6_second_meas", meas_o, 1);
        chk("t6_width",  width_o, 4);
        chk("t6_height", height_o, 3);
        chk("t6_fcnt",   frame_cnt_o, 1);
        $display("reset mid-frame: w=%0d h=%0d fc=%0d", width_o, height_o, frame_cnt_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_video_mon.md
# axis_video_mon

Zero-latency AXI4-Stream video passthrough with a registered measurement and protocol-check side channel. It sits inline between any two video AXIS stages and replaces the single-purpose frame/line counter monitor. It measures active width, active height, frames per second, frame total and backpressure stall cycles per second. It flags malformed line/frame structure with sticky error bits that firmware or ILA can read and clear.

## Interface
- TDATA_WIDTH, 48, pixel bus width
- TUSER_WIDTH, 1, tuser width; bit 0 is start-of-frame (SOF)
- FREQ_HZ, 100000000, aclk cycles per measurement window (1 s)
- DIM_WIDTH, 16, width of pixel/line counters and width/height outputs

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- s_axis_tvalid / s_axis_tready / s_axis_tdata / s_axis_tlast / s_axis_tuser  in/out/in/in/in  1/1/TDATA_WIDTH/1/TUSER_WIDTH  upstream stream
- m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast / m_axis_tuser  out/in/out/out/out  same widths  downstream stream
- clr_sticky  in  1  one-cycle clear of the err_* bits
- width_o  out  DIM_WIDTH  beats per line of the last complete frame (from its first line)
- height_o  out  DIM_WIDTH  lines (tlast count) in the last complete frame
- fps_o  out  16  frames started in the last completed window
- stall_o  out  32  cycles with s_tvalid & !m_tready in the last completed window
- frame_cnt_o  out  32  total frames completed since reset; wraps
- meas_valid_o  out  1  one-cycle pulse when width_o/height_o/frame_cnt_o update
- err_eol_early_o, err_eol_late_o, err_sof_early_o  out  1 each  sticky protocol errors

## Operation
- Passthrough is purely combinational: m_* = s_*, and s_axis_tready = m_axis_tready. The monitor never stalls, alters or drops beats.
- Event definitions:
  - beat = s_tvalid & m_tready
  - sof = beat & tuser[0]
  - eol = beat & tlast
- pix_cnt (DIM_WIDTH) counts beats in the current line.
  - Cleared on eol, with line length L = pix_cnt+1.
  - On sof, restarts so that the SOF beat counts as pixel 1.
  - Saturates at all-ones; does not wrap.
- ref_w: L of the first eol after each SOF. Every later eol in that frame compares L to ref_w.
  - L < ref_w sets err_eol_early.
  - L > ref_w sets err_eol_late.
- err_sof_early: set by sof while pix_cnt != 0, i.e. SOF arriving mid-line. That partial line is discarded and not counted in line_cnt.
- line_cnt: counts eol within a frame; cleared on sof.
- Frame close, on each sof after the first SOF following reset:
  - width_o ← ref_w
  - height_o ← line_cnt (+1 if the same beat is also eol)
  - frame_cnt_o increments
  - meas_valid_o pulses
- A beat with both tuser[0] and tlast is a one-beat line that opens a new frame. It closes the previous frame, then sets ref_w = 1 and line_cnt = 1.
- Window counter runs 0..FREQ_HZ-1. On the terminal cycle:
  - fps_o ← win_frames (+1 if sof in that same cycle); win_frames ← 0
  - stall_o ← win_stall (+1 if stalling in that cycle); win_stall ← 0
- Saturation: win_frames saturates at 0xFFFF; win_stall saturates at 0xFFFFFFFF.
- Sticky errors: cleared by clr_sticky. A set event in the same cycle as clr_sticky wins, so the bit stays 1.

## Timing
- m_* and s_axis_tready: 0 cycles latency.
- All monitor outputs are registered and reflect an event one cycle after the triggering beat's clock edge.
- Reset (aresetn=0 at a clock edge) clears every counter, every register output and the seen-first-SOF flag; meas_valid_o = 0.
- Reset mid-frame: after release, no frame is published until the second SOF.
- No beat, meaning tvalid without tready, changes any counter except win_stall.
- tready without tvalid is not a beat.

## Test plan
- Three frames of 4 beats × 3 lines (SOF on the first beat) with tready always high, FREQ_HZ = 1000 in bench:
  - meas_valid pulses on the 2nd and 3rd SOF.
  - width_o = 4, height_o = 3, frame_cnt_o = 2.
  - No err bits set.
- Same stream with tready low on every 3rd cycle:
  - Measurements are identical.
  - stall_o equals the count of tvalid&!tready cycles within the window.
  - m_* mirror s_* every cycle.
- Frame with lines of 4, 3 and 5 beats:
  - err_eol_early = 1 after the 2nd tlast.
  - err_eol_late = 1 after the 3rd tlast.
  - clr_sticky pulse clears both.
  - clr_sticky asserted with a coinciding new error leaves the bit at 1.
- SOF asserted on pixel 3 of a line:
  - err_sof_early = 1.
  - The published height excludes the partial line.
  - The new frame's pix_cnt starts at 1.
- Frames every 100 cycles with FREQ_HZ = 1000:
  - fps_o = 10 after the first window.
  - An SOF on the terminal window cycle is counted in that window.
- aresetn pulsed mid-frame:
  - All outputs = 0.
  - The first SOF after release does not pulse meas_valid; the second does, with correct width/height.
